// File: rtl/midi_pkg.sv
// Shared MIDI constants and types used by both the transmit encoder and the
// receive-side status decoder.
package midi_pkg;

  localparam logic [3:0] ST_NOTE_OFF = 4'h8;
  localparam logic [3:0] ST_NOTE_ON  = 4'h9;
  localparam logic [3:0] ST_CTRL     = 4'hB;
  localparam logic [3:0] ST_PRG      = 4'hC;
  localparam logic [3:0] ST_PITCH    = 4'hE;

  typedef enum logic [2:0] {
    EV_NOTE_OFF = 3'd0,
    EV_NOTE_ON  = 3'd1,
    EV_CTRL     = 3'd2,
    EV_PRG      = 3'd3,
    EV_PITCH    = 3'd4
  } ev_type_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STATUS,
    S_DATA1,
    S_DATA2
  } enc_state_e;

  function automatic logic ev_type_ok(input logic [2:0] t);
    return t <= 3'd4;
  endfunction

  // High nibble of the status byte; 0 for types that have no encoding.
  function automatic logic [3:0] status_nibble(input ev_type_e t, input logic note_off_as_on);
    case (t)
      EV_NOTE_OFF: return note_off_as_on ? ST_NOTE_ON : ST_NOTE_OFF;
      EV_NOTE_ON:  return ST_NOTE_ON;
      EV_CTRL:     return ST_CTRL;
      EV_PRG:      return ST_PRG;
      EV_PITCH:    return ST_PITCH;
      default:     return 4'h0;
    endcase
  endfunction

endpackage

// File: rtl/midi_rs_tracker.sv
// Running-status tracker: remembers the last status byte sent and how long the
// output has been idle, and reports whether a status byte may be omitted.
module midi_rs_tracker
  import midi_pkg::*;
#(
  parameter int unsigned RS_TIMEOUT = 50000000,
  parameter int unsigned RS_CW      = 26
) (
  input  logic       CLOCK_50,
  input  logic       reset_reg,
  input  logic       strobe,
  input  logic       status_sent,
  input  logic [7:0] sent_status,
  input  logic [7:0] query_status,
  output logic       rs_hit
);

  localparam logic [RS_CW-1:0] TIMEOUT = RS_CW'(RS_TIMEOUT);

  logic [7:0]       last_status;
  logic [RS_CW-1:0] idle_cnt;

  // NOTE: async reset lives in the sensitivity list; the counter starts expired
  // so the first message after reset always carries its status byte.
  always_ff @(posedge CLOCK_50 or posedge reset_reg) begin
    if (reset_reg) begin
      last_status <= 8'h00;
      idle_cnt    <= TIMEOUT;
    end else begin
      if (status_sent) last_status <= sent_status;
      if (strobe)                  idle_cnt <= '0;
      else if (idle_cnt < TIMEOUT) idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign rs_hit = (query_status == last_status) && (idle_cnt < TIMEOUT);

endmodule

// File: rtl/midi_msg_encoder.sv
// Channel-voice event to MIDI byte stream encoder with running status, feeding
// the UART transmit byte port one strobe at a time.
module midi_msg_encoder
  import midi_pkg::*;
#(
  parameter bit          RUNNING_STATUS = 1'b1,
  parameter bit          NOTE_OFF_AS_ON = 1'b1,
  parameter int unsigned RS_TIMEOUT     = 50000000,
  parameter int unsigned RS_CW          = 26
) (
  input  logic        CLOCK_50,
  input  logic        reset_reg,
  input  logic        ev_valid,
  output logic        ev_ready,
  input  logic [2:0]  ev_type,
  input  logic [3:0]  ev_ch,
  input  logic [7:0]  ev_data1,
  input  logic [7:0]  ev_data2,
  input  logic [13:0] ev_bend,
  input  logic        midi_out_ready,
  output logic        midi_send_byte,
  output logic [7:0]  midi_out_data,
  output logic        busy,
  output logic        ev_drop
);

  enc_state_e state;
  ev_type_e   ev_kind;
  logic [7:0] ev_status, ev_d1, ev_d2;
  logic [7:0] status_q, d1_q, d2_q;
  logic       two_byte_q;
  logic       issue, rs_hit, unused_bits;

  assign ev_kind     = ev_type_e'(ev_type);
  assign ev_status   = {status_nibble(ev_kind, NOTE_OFF_AS_ON), ev_ch};
  assign unused_bits = ^{ev_data1[7], ev_data2[7]};

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    ev_d1 = {1'b0, ev_data1[6:0]};
    ev_d2 = {1'b0, ev_data2[6:0]};
    if (ev_kind == EV_PITCH) begin
      ev_d1 = {1'b0, ev_bend[6:0]};
      ev_d2 = {1'b0, ev_bend[13:7]};
    end else if (ev_kind == EV_NOTE_OFF && NOTE_OFF_AS_ON) begin
      ev_d2 = 8'h00;
    end
  end

  // A byte goes out only when the UART can take it and the previous cycle was
  // not itself a strobe, so strobes are never back to back.
  assign issue = (state != S_IDLE) && midi_out_ready && !midi_send_byte;

  midi_rs_tracker #(
    .RS_TIMEOUT (RS_TIMEOUT),
    .RS_CW      (RS_CW)
  ) u_rs (
    .CLOCK_50     (CLOCK_50),
    .reset_reg    (reset_reg),
    .strobe       (issue),
    .status_sent  (issue && state == S_STATUS),
    .sent_status  (status_q),
    .query_status (ev_status),
    .rs_hit       (rs_hit)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_50 or posedge reset_reg) begin
    if (reset_reg) begin
      state          <= S_IDLE;
      ev_ready       <= 1'b0;
      midi_send_byte <= 1'b0;
      midi_out_data  <= 8'h00;
      busy           <= 1'b0;
      ev_drop        <= 1'b0;
      status_q       <= 8'h00;
      d1_q           <= 8'h00;
      d2_q           <= 8'h00;
      two_byte_q     <= 1'b0;
    end else begin
      midi_send_byte <= 1'b0;
      ev_drop        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ev_valid && ev_ready) begin
            ev_ready <= 1'b0;
            if (!ev_type_ok(ev_type)) begin
              ev_drop <= 1'b1;
            end else begin
              status_q   <= ev_status;
              d1_q       <= ev_d1;
              d2_q       <= ev_d2;
              two_byte_q <= (ev_kind == EV_PRG);
              busy       <= 1'b1;
              state      <= (RUNNING_STATUS && rs_hit) ? S_DATA1 : S_STATUS;
            end
          end else begin
            ev_ready <= 1'b1;
          end
        end
        S_STATUS: if (issue) begin
          midi_send_byte <= 1'b1;
          midi_out_data  <= status_q;
          state          <= S_DATA1;
        end
        S_DATA1: if (issue) begin
          midi_send_byte <= 1'b1;
          midi_out_data  <= d1_q;
          if (two_byte_q) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            ev_ready <= 1'b1;
          end else begin
            state <= S_DATA2;
          end
        end
        S_DATA2: if (issue) begin
          midi_send_byte <= 1'b1;
          midi_out_data  <= d2_q;
          state          <= S_IDLE;
          busy           <= 1'b0;
          ev_ready       <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_midi_msg_encoder.sv
// Scoreboard bench for midi_msg_encoder: stimulus pushes expected bytes, a
// negedge monitor pops and compares on every midi_send_byte strobe.
module tb_midi_msg_encoder;

  logic        CLOCK_50 = 1'b0;
  logic        reset_reg = 1'b1;
  logic        ev_valid = 1'b0;
  logic        ev_ready;
  logic [2:0]  ev_type = 3'd0;
  logic [3:0]  ev_ch = 4'd0;
  logic [7:0]  ev_data1 = 8'h00;
  logic [7:0]  ev_data2 = 8'h00;
  logic [13:0] ev_bend = 14'h0;
  logic        midi_out_ready = 1'b1;
  logic        midi_send_byte;
  logic [7:0]  midi_out_data;
  logic        busy;
  logic        ev_drop;

  midi_msg_encoder #(
    .RUNNING_STATUS (1'b1),
    .NOTE_OFF_AS_ON (1'b1),
    .RS_TIMEOUT     (100),
    .RS_CW          (8)
  ) dut (
    .CLOCK_50       (CLOCK_50),
    .reset_reg      (reset_reg),
    .ev_valid       (ev_valid),
    .ev_ready       (ev_ready),
    .ev_type        (ev_type),
    .ev_ch          (ev_ch),
    .ev_data1       (ev_data1),
    .ev_data2       (ev_data2),
    .ev_bend        (ev_bend),
    .midi_out_ready (midi_out_ready),
    .midi_send_byte (midi_send_byte),
    .midi_out_data  (midi_out_data),
    .busy           (busy),
    .ev_drop        (ev_drop)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] sb[$];
  int         strobe_cyc[$];
  int         last_strobe_cyc = 0;
  int         acc_cyc = 0;
  logic       prev_strobe = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge CLOCK_50) begin
    if (midi_send_byte === 1'b1) begin
      check("no_back_to_back", {31'd0, prev_strobe}, 32'd0);
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_byte: got 0x%0h expected no strobe", midi_out_data);
      end else begin
        check("byte", {24'd0, midi_out_data}, {24'd0, sb.pop_front()});
      end
      strobe_cyc.push_back(cyc);
      last_strobe_cyc = cyc;
    end
    prev_strobe = midi_send_byte;
  end

  // Call from a negedge; returns just after the accepting posedge.
  task automatic issue(input logic [2:0] t, input logic [3:0] ch, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [13:0] bend);
    int n;
    ev_type  = t;
    ev_ch    = ch;
    ev_data1 = d1;
    ev_data2 = d2;
    ev_bend  = bend;
    ev_valid = 1'b1;
    n = 0;
    while (ev_ready !== 1'b1 && n < 200) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("ev_ready_wait", {31'd0, ev_ready}, 32'd1);
    @(posedge CLOCK_50);
    #1;
    acc_cyc  = cyc;
    ev_valid = 1'b0;
  endtask

  task automatic wait_done();
    int  n;
    logic done;
    n = 0;
    done = 1'b0;
    while (!done && n < 500) begin
      @(negedge CLOCK_50);
      #1;
      done = (sb.size() == 0) && (busy === 1'b0) && (ev_ready === 1'b1);
      n++;
    end
    check("message_done", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_strobes(input int count);
    int seen, n;
    seen = 0;
    n = 0;
    while (seen < count && n < 200) begin
      @(negedge CLOCK_50);
      #1;
      if (midi_send_byte === 1'b1) seen++;
      n++;
    end
    check("strobe_wait", seen, count);
  endtask

  task automatic idle_until(input int k);
    while (cyc < last_strobe_cyc + k) @(negedge CLOCK_50);
  endtask

  initial begin
    #1_000_000;
    $display("Watchdog expired at cycle %0d", cyc);
    $fatal(1, "simulation watchdog");
  end

  initial begin
    // Reset values
    @(negedge CLOCK_50);
    #1;
    check("rst_ev_ready", {31'd0, ev_ready}, 32'd0);
    check("rst_send",     {31'd0, midi_send_byte}, 32'd0);
    check("rst_data",     {24'd0, midi_out_data}, 32'h00);
    check("rst_busy",     {31'd0, busy}, 32'd0);
    check("rst_drop",     {31'd0, ev_drop}, 32'd0);
    reset_reg = 1'b0;
    @(negedge CLOCK_50);
    check("ready_after_rst", {31'd0, ev_ready}, 32'd1);

    // Full note on with strobe timing t+1, t+3, t+5
    strobe_cyc.delete();
    sb.push_back(8'h93); sb.push_back(8'h3C); sb.push_back(8'h64);
    issue(3'd1, 4'd3, 8'h3C, 8'h64, 14'h0);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    wait_done();
    check("t1_nbytes", strobe_cyc.size(), 3);
    if (strobe_cyc.size() == 3) begin
      check("t1_cyc1", strobe_cyc[0], acc_cyc + 1);
      check("t1_cyc2", strobe_cyc[1], acc_cyc + 3);
      check("t1_cyc3", strobe_cyc[2], acc_cyc + 5);
    end

    // Running status: second note on, then note off sent as 0x93 vel 0
    sb.push_back(8'h40); sb.push_back(8'h50);
    issue(3'd1, 4'd3, 8'h40, 8'h50, 14'h0);
    wait_done();
    sb.push_back(8'h3C); sb.push_back(8'h00);
    issue(3'd0, 4'd3, 8'h3C, 8'h7F, 14'h0);
    wait_done();

    // Pitch bend, then program change with masked data and no third byte
    sb.push_back(8'hE0); sb.push_back(8'h01); sb.push_back(8'h40);
    issue(3'd4, 4'd0, 8'h00, 8'h00, 14'h2001);
    wait_done();
    strobe_cyc.delete();
    sb.push_back(8'hCF); sb.push_back(8'h05);
    issue(3'd3, 4'd15, 8'h85, 8'h77, 14'h0);
    wait_done();
    repeat (4) @(negedge CLOCK_50);
    check("prg_two_bytes", strobe_cyc.size(), 2);

    // Timeout boundary: 99 idle cycles keeps running status, 100 expires it
    idle_until(99);
    sb.push_back(8'h10);
    issue(3'd3, 4'd15, 8'h10, 8'h00, 14'h0);
    wait_done();
    idle_until(100);
    sb.push_back(8'hCF); sb.push_back(8'h11);
    issue(3'd3, 4'd15, 8'h11, 8'h00, 14'h0);
    wait_done();

    // Stall mid-message for 20 cycles
    @(negedge CLOCK_50);
    sb.push_back(8'hB5); sb.push_back(8'h07); sb.push_back(8'h7F);
    issue(3'd2, 4'd5, 8'h07, 8'hFF, 14'h0);
    wait_strobes(1);
    midi_out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLOCK_50);
      #1;
      check("stall_no_strobe", {31'd0, midi_send_byte}, 32'd0);
      check("stall_data_hold", {24'd0, midi_out_data}, 32'hB5);
    end
    check("stall_busy", {31'd0, busy}, 32'd1);
    midi_out_ready = 1'b1;
    wait_done();

    // Reset between DATA1 and DATA2, then the next note sends its status byte
    @(negedge CLOCK_50);
    sb.push_back(8'h92); sb.push_back(8'h30);
    issue(3'd1, 4'd2, 8'h30, 8'h20, 14'h0);
    wait_strobes(2);
    reset_reg = 1'b1;
    #1;
    check("abort_ev_ready", {31'd0, ev_ready}, 32'd0);
    check("abort_send",     {31'd0, midi_send_byte}, 32'd0);
    check("abort_data",     {24'd0, midi_out_data}, 32'h00);
    check("abort_busy",     {31'd0, busy}, 32'd0);
    check("abort_sb_empty", sb.size(), 0);
    @(negedge CLOCK_50);
    reset_reg = 1'b0;
    @(negedge CLOCK_50);
    sb.push_back(8'h92); sb.push_back(8'h30); sb.push_back(8'h20);
    issue(3'd1, 4'd2, 8'h30, 8'h20, 14'h0);
    wait_done();

    // Invalid type is dropped; running status survives it
    @(negedge CLOCK_50);
    issue(3'd6, 4'd2, 8'h55, 8'h55, 14'h0);
    check("drop_pulse",     {31'd0, ev_drop}, 32'd1);
    check("drop_not_busy",  {31'd0, busy}, 32'd0);
    check("drop_ready_low", {31'd0, ev_ready}, 32'd0);
    @(posedge CLOCK_50);
    #1;
    check("drop_one_cycle", {31'd0, ev_drop}, 32'd0);
    repeat (5) @(negedge CLOCK_50);
    sb.push_back(8'h31); sb.push_back(8'h22);
    issue(3'd1, 4'd2, 8'h31, 8'h22, 14'h0);
    wait_done();
    repeat (4) @(negedge CLOCK_50);
    check("final_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/midi_msg_encoder.md
Name: midi_msg_encoder

Overview:
- Encodes channel-voice events (note on/off, control change, program change, pitch bend) into MIDI byte sequences for the MIDI UART transmit byte port.
- This is the transmit-direction counterpart of the MIDI input parsing path.
- Supports running status with an idle timeout.
- Sits between event sources (CPU port or sequencer) and the UART midi_send_byte/midi_out_data interface.

Parameters:
- RUNNING_STATUS, 1, when 1 the status byte is omitted if it equals the last sent status and has not timed out.
- NOTE_OFF_AS_ON, 1, when 1 note-off is sent as 0x9n with velocity 0x00.
- RS_TIMEOUT, 50000000, idle cycles after which running status is invalidated (1 s at 50 MHz).
- RS_CW, 26, width of the idle counter; must satisfy 2^RS_CW > RS_TIMEOUT.

Ports:
- CLOCK_50 input 1: system clock.
- reset_reg input 1: asynchronous active-high reset.
- ev_valid input 1: event request.
- ev_ready output 1: encoder can accept an event.
- ev_type input 3: 0 note off, 1 note on, 2 control change, 3 program change, 4 pitch bend, 5-7 invalid.
- ev_ch input 4: MIDI channel 0-15.
- ev_data1 input 8: key, controller or program number; bit 7 ignored.
- ev_data2 input 8: velocity or controller value; bit 7 ignored.
- ev_bend input 14: pitch bend value; 0x2000 is centre.
- midi_out_ready input 1: UART transmit buffer can take a byte.
- midi_send_byte output 1: one-cycle strobe; midi_out_data is valid this cycle.
- midi_out_data output 8: byte to transmit.
- busy output 1: high while not IDLE.
- ev_drop output 1: one-cycle pulse when an invalid ev_type is accepted and discarded.

Behaviour:
- Reset values: ev_ready=0, midi_send_byte=0, midi_out_data=0x00, busy=0, ev_drop=0, state=IDLE, last_status=0x00 (none), idle_cnt=RS_TIMEOUT (running status expired). All outputs are registered.
- ev_ready=1 in IDLE from the first cycle after reset release. An event is accepted when ev_valid && ev_ready. The accepted fields are latched. ev_ready drops on the next cycle.
- Status formation:
  - note off: 0x8n, or 0x9n when NOTE_OFF_AS_ON=1, in which case d2 is forced to 0x00.
  - note on: 0x9n.
  - control change: 0xBn.
  - program change: 0xCn.
  - pitch bend: 0xEn with d1=ev_bend[6:0] and d2=ev_bend[13:7].
  - All data bytes are masked to 7 bits.
- Invalid type: ev_drop pulses the cycle after acceptance. No bytes are sent. State returns to IDLE and last_status is unchanged.
- States: IDLE -> STATUS -> DATA1 -> DATA2 -> IDLE.
  - STATUS is skipped (go directly to DATA1) when RUNNING_STATUS=1, status==last_status and idle_cnt<RS_TIMEOUT.
  - For program change, DATA2 is skipped (DATA1 -> IDLE).
- Byte issue rule: in STATUS/DATA1/DATA2, the byte is issued in any cycle where midi_out_ready=1 and midi_send_byte was 0 in the previous cycle. The issue sets midi_send_byte=1 for exactly one cycle with midi_out_data, and the state advances. No two consecutive strobe cycles occur. With midi_out_ready held at 1, a 3-byte message takes strobes on cycles t+1, t+3, t+5 after acceptance at t.
- midi_out_data holds the last byte between strobes.
- last_status is updated when the status byte is sent.
- idle_cnt clears to 0 on every strobe and increments each cycle, saturating at RS_TIMEOUT.
- midi_out_ready low stalls indefinitely. No timeout applies to the stall, but idle_cnt still counts.
- Reset mid-message aborts immediately. The next message always sends its status byte.
- ev_valid while busy is ignored: the source must hold ev_valid until ev_ready.

Decomposition:
- Shared package midi_pkg:
  - status-nibble constants: ST_NOTE_OFF=4'h8, ST_NOTE_ON=4'h9, ST_CTRL=4'hB, ST_PRG=4'hC, ST_PITCH=4'hE.
  - ev_type enum.
  - encoder state enum.
  - These constants are shared with the receive-side status decoder.
- One sub-module is natural: midi_rs_tracker. It holds last_status and idle_cnt and outputs rs_hit = (status==last_status && idle_cnt<RS_TIMEOUT). It is reusable for a future sysex/realtime arbiter.

Test Plan:
- Note on, ch 3, key 0x3C, vel 0x64, ready=1 -> bytes 0x93, 0x3C, 0x64 on cycles t+1, t+3, t+5; then ev_ready returns.
- A second note on, ch 3, key 0x40, vel 0x50 within the timeout -> only 0x40, 0x50. Note off key 0x3C, NOTE_OFF_AS_ON=1 -> only 0x3C, 0x00.
- Pitch bend ch 0, ev_bend=0x2001 -> 0xE0, 0x01, 0x40. Program change ch 15, data 0x85 -> 0xCF, 0x05 (masked), with no third byte.
- Same-status note after RS_TIMEOUT idle cycles (bench overrides RS_TIMEOUT to 100) -> status byte is re-sent. At 99 idle cycles it is omitted.
- midi_out_ready held low 20 cycles mid-message, then high -> no strobe while low, remaining bytes in order, data unchanged. Reset asserted between DATA1 and DATA2 -> outputs return to reset values, and the next note on sends its full 3 bytes.
- ev_type=6 -> ev_drop pulse, no strobe, next valid event encodes normally with running status preserved.
